// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 7-segment capture slice.
//   seg_t      - 7-bit segment pattern, bit0=a ... bit6=g, active high
//   digit_t    - 4-bit decoded digit
//   SEG_*      - canonical segment patterns for 0..9, A..F and blank
//   stab_cnt_width() / STAB_CNT_W - width of the stability counter,
//                enough to hold STABLE_CYCLES
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;

  localparam int STABLE_CYCLES_DEFAULT = 16;

  function automatic int stab_cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

  localparam int STAB_CNT_W = stab_cnt_width(STABLE_CYCLES_DEFAULT);

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational segment pattern -> digit decoder.
//   pattern - 7-bit segment pattern to decode
//   legal   - high when pattern is a recognised digit
//   digit   - decoded value, only meaningful while legal is high
// Build option: SEG7_CAPTURE_HEX_EN makes the A..F glyphs legal digits;
// without it those glyphs decode as illegal.
module seg7_decode
  import seg7_pkg::*;
(
  input  seg_t   pattern,
  output logic   legal,
  output digit_t digit
);

`ifdef SEG7_CAPTURE_HEX_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  // Table lookup; hex glyphs are always recognised here and their legality
  // follows the build option, so both builds share one case statement.
  always_comb begin
    legal = 1'b1;
    digit = 4'h0;
    case (pattern)
      SEG_0: digit = 4'h0;
      SEG_1: digit = 4'h1;
      SEG_2: digit = 4'h2;
      SEG_3: digit = 4'h3;
      SEG_4: digit = 4'h4;
      SEG_5: digit = 4'h5;
      SEG_6: digit = 4'h6;
      SEG_7: digit = 4'h7;
      SEG_8: digit = 4'h8;
      SEG_9: digit = 4'h9;
      SEG_A: begin legal = HEX_EN; digit = 4'hA; end
      SEG_B: begin legal = HEX_EN; digit = 4'hB; end
      SEG_C: begin legal = HEX_EN; digit = 4'hC; end
      SEG_D: begin legal = HEX_EN; digit = 4'hD; end
      SEG_E: begin legal = HEX_EN; digit = 4'hE; end
      SEG_F: begin legal = HEX_EN; digit = 4'hF; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: receive side of the 7-segment digit link.
// Synchronises an asynchronous segment bus, debounces it, decodes stable
// patterns to digits, flags illegal patterns and checks that successive
// digits count up by one (SEQ_MAX wraps to 0).
//   clk, rst_n   - clock, asynchronous active-low reset
//   seg_in       - asynchronous segment bus (bit0=a ... bit6=g)
//   clear        - zeroes err_count and seq_count
//   digit_out    - last accepted legal digit
//   digit_valid  - accepted pattern is a legal digit
//   blank        - accepted pattern is all segments off
//   digit_stb    - one-cycle pulse per newly accepted pattern
//   bad_pattern  - one-cycle pulse when the accepted pattern is illegal
//   seq_err      - one-cycle pulse when a legal digit breaks the count
//   err_count    - saturating count of bad_pattern pulses
//   seq_count    - saturating count of seq_err pulses
// Build option: SEG7_CAPTURE_HEX_EN (see seg7_decode) adds A..F digits.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int SEQ_MAX       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       clear,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       blank,
  output logic       digit_stb,
  output logic       bad_pattern,
  output logic       seq_err,
  output logic [7:0] err_count,
  output logic [7:0] seq_count
);

  localparam int              CNT_W    = stab_cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam digit_t          SEQ_LAST = digit_t'(SEQ_MAX);

  seg_t             s1, s2;
  seg_t             candidate;
  seg_t             accepted;
  logic [CNT_W-1:0] stab_cnt;
  digit_t           prev;
  logic             hist_valid;

  logic             dec_legal;
  digit_t           dec_digit;
  logic             accept;
  digit_t           expect_next;

  seg7_decode u_decode (
    .pattern (candidate),
    .legal   (dec_legal),
    .digit   (dec_digit)
  );

  assign accept      = (stab_cnt == CNT_LAST) && (candidate != accepted);
  assign expect_next = (prev == SEQ_LAST) ? 4'h0 : prev + 4'h1;

  // Two-flop synchroniser; nothing else may look at seg_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= SEG_BLANK;
      s2 <= SEG_BLANK;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
    end
  end

  // Stability filter: any change restarts the count; the count parks at
  // its last value so a steady pattern is only ever accepted once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= SEG_BLANK;
      stab_cnt  <= '0;
    end else if (s2 != candidate) begin
      candidate <= s2;
      stab_cnt  <= '0;
    end else if (stab_cnt != CNT_LAST) begin
      stab_cnt  <= stab_cnt + CNT_W'(1);
    end
  end

  // Acceptance, decode results and sequence tracking. Blank and illegal
  // patterns both break the sequence so the next digit starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted    <= SEG_BLANK;
      digit_out   <= 4'h0;
      digit_valid <= 1'b0;
      blank       <= 1'b0;
      digit_stb   <= 1'b0;
      bad_pattern <= 1'b0;
      seq_err     <= 1'b0;
      prev        <= 4'h0;
      hist_valid  <= 1'b0;
    end else begin
      digit_stb   <= 1'b0;
      bad_pattern <= 1'b0;
      seq_err     <= 1'b0;
      if (accept) begin
        accepted  <= candidate;
        digit_stb <= 1'b1;
        if (candidate == SEG_BLANK) begin
          digit_valid <= 1'b0;
          blank       <= 1'b1;
          hist_valid  <= 1'b0;
        end else if (dec_legal) begin
          digit_out   <= dec_digit;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          seq_err     <= hist_valid && (dec_digit != expect_next);
          prev        <= dec_digit;
          hist_valid  <= 1'b1;
        end else begin
          digit_valid <= 1'b0;
          blank       <= 1'b0;
          bad_pattern <= 1'b1;
          hist_valid  <= 1'b0;
        end
      end
    end
  end

  // Error counters count the registered pulses; clear beats a coincident
  // increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
      seq_count <= 8'h00;
    end else if (clear) begin
      err_count <= 8'h00;
      seq_count <= 8'h00;
    end else begin
      if (bad_pattern && (err_count != 8'hFF)) err_count <= err_count + 8'h01;
      if (seq_err && (seq_count != 8'hFF))     seq_count <= seq_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: scoreboard bench for seg7_capture (STABLE_CYCLES=16,
// SEQ_MAX=8). Stimulus pushes the hand-computed response of each expected
// accept, including the cycle it must appear on; a monitor pops and
// compares whenever digit_stb is seen. Honours SEG7_CAPTURE_HEX_EN.
module tb_seg7_capture;

  import seg7_pkg::*;

`ifdef SEG7_CAPTURE_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  // seg_in changed at a negedge with cyc=N is first sampled at the next
  // edge, and the accept must be visible at the negedge where cyc=N+19.
  localparam int LATENCY = 16 + 2 + 1;

  typedef struct {
    int         cyc;
    logic [3:0] digit;
    logic       valid;
    logic       blk;
    logic       bad;
    logic       seq;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       clear;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       blank;
  logic       digit_stb;
  logic       bad_pattern;
  logic       seq_err;
  logic [7:0] err_count;
  logic [7:0] seq_count;

  int   cyc;
  int   vectors;
  int   miscompares;
  bit   finished;
  exp_t sb_q[$];

  seg7_capture #(.STABLE_CYCLES(16), .SEQ_MAX(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .clear       (clear),
    .digit_out   (digit_out),
    .digit_valid (digit_valid),
    .blank       (blank),
    .digit_stb   (digit_stb),
    .bad_pattern (bad_pattern),
    .seq_err     (seq_err),
    .err_count   (err_count),
    .seq_count   (seq_count)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Called just after a negedge; drives a pattern, optionally queues the
  // accept it must cause, then holds it for the given number of cycles.
  task automatic apply_stimulus(input logic [6:0] pat, input int hold, input bit stb_exp,
                                input logic [3:0] dg, input bit vld, input bit blk,
                                input bit bad, input bit seq);
    exp_t e;
    seg_in = pat;
    if (stb_exp) begin
      e.cyc = cyc + LATENCY; e.digit = dg; e.valid = vld;
      e.blk = blk; e.bad = bad; e.seq = seq;
      sb_q.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  task automatic finish_run();
    if (!finished) begin
      finished = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && digit_stb) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_stb", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_output("stb_cycle",   cyc,         e.cyc);
        check_output("digit_out",   digit_out,   e.digit);
        check_output("digit_valid", digit_valid, e.valid);
        check_output("blank",       blank,       e.blk);
        check_output("bad_pattern", bad_pattern, e.bad);
        check_output("seq_err",     seq_err,     e.seq);
      end
    end
  end

  // Watchdog so the run always ends with a summary.
  initial begin
    #(50000 * 100);
    check_output("watchdog_timeout", 32'd1, 32'd0);
    finish_run();
  end

  initial begin
    logic [6:0] pats[10];
    logic [3:0] hex_digit;
    bit         seen;
    cyc = 0; vectors = 0; miscompares = 0; finished = 1'b0;
    pats[0] = 7'h3F; pats[1] = 7'h06; pats[2] = 7'h5B; pats[3] = 7'h4F; pats[4] = 7'h66;
    pats[5] = 7'h6D; pats[6] = 7'h7D; pats[7] = 7'h07; pats[8] = 7'h7F; pats[9] = 7'h3F;
    hex_digit = HEX ? 4'hA : 4'h3;

    rst_n = 1'b0; seg_in = 7'h00; clear = 1'b0;
    repeat (3) @(negedge clk);
    check_output("rst_digit_out",   digit_out,   4'h0);
    check_output("rst_digit_valid", digit_valid, 1'b0);
    check_output("rst_blank",       blank,       1'b0);
    check_output("rst_digit_stb",   digit_stb,   1'b0);
    check_output("rst_bad_pattern", bad_pattern, 1'b0);
    check_output("rst_seq_err",     seq_err,     1'b0);
    check_output("rst_err_count",   err_count,   8'h00);
    check_output("rst_seq_count",   seq_count,   8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Count 0..8 then wrap to 0; no sequence errors.
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(pats[i], 30, 1'b1, (i == 9) ? 4'd0 : 4'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_output("seq_count_after_count", seq_count, 8'd0);

    // 1,2,3 then skip to 5 (error), then 6 is in sequence again.
    apply_stimulus(7'h06, 30, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(7'h5B, 30, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(7'h4F, 30, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    apply_stimulus(7'h6D, 30, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    apply_stimulus(7'h7D, 30, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("seq_count_after_skip", seq_count, 8'd1);

    // Blank breaks history, then 3 is accepted without error.
    apply_stimulus(7'h00, 30, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(7'h4F, 30, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Short glitch on a held pattern: no strobe, state unchanged.
    apply_stimulus(7'h00, 5,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(7'h4F, 30, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("glitch_digit_out",   digit_out,   4'd3);
    check_output("glitch_digit_valid", digit_valid, 1'b1);
    check_output("glitch_blank",       blank,       1'b0);

    // Hex glyph A after a blank.
    apply_stimulus(7'h00, 30, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(7'h77, 30, 1'b1, hex_digit, HEX, 1'b0, !HEX, 1'b0);
    check_output("err_count_after_77", err_count, HEX ? 8'd0 : 8'd1);
    check_output("valid_after_77",     digit_valid, HEX);

    // 300 illegal accepts saturate err_count.
    for (int i = 0; i < 300; i++) begin
      apply_stimulus((i % 2 == 0) ? 7'h01 : 7'h02, 20, 1'b1, hex_digit, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    repeat (2) @(negedge clk);
    check_output("err_count_saturated", err_count, 8'd255);
    check_output("seq_count_before_clr", seq_count, 8'd1);

    // Clear while a bad_pattern pulse is present.
    apply_stimulus(7'h01, 0, 1'b1, hex_digit, 1'b0, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bad_pattern) seen = 1'b1;
    end
    check_output("bad_pattern_seen", seen, 1'b1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check_output("err_count_cleared", err_count, 8'd0);
    check_output("seq_count_cleared", seq_count, 8'd0);

    // Reset mid-filter, then a full-latency accept from scratch.
    apply_stimulus(7'h06, 8, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_output("midrst_digit_out",   digit_out,   4'h0);
    check_output("midrst_digit_valid", digit_valid, 1'b0);
    check_output("midrst_blank",       blank,       1'b0);
    check_output("midrst_digit_stb",   digit_stb,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(7'h06, 30, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check_output("pending_stb", sb_q.size(), 32'd0);
    finish_run();
  end

endmodule
